// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage. Owns the fetch PC, issues one
//   outstanding request at a time to instruction memory and buffers returned
//   words with their PC in a DEPTH-entry FIFO whose head feeds Decode.
// Latency: a word appears on InstrD the cycle after its imem_rvalid.
// Backpressure: StallD holds the head; when the buffer cannot take the reply
//   of a new request, the request is not raised. A pop does not count as free
//   space in the same cycle.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   PCSrcE, PCTargetE      Execute redirect (flush + new fetch PC)
//   StallD                 Decode not accepting the head entry
//   imem_req/addr/gnt      request channel to instruction memory
//   imem_rvalid/rdata      response channel from instruction memory
//   ValidD/InstrD/PCD/PCPlus4D  head entry presented to Decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_RUN  = 2'd0;  // nothing outstanding
  localparam logic [1:0] S_WAIT = 2'd1;  // live request awaiting its response
  localparam logic [1:0] S_DROP = 2'd2;  // stale response still to arrive

  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ALMOST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;          // next address to fetch
  logic [31:0]   req_pc_q, req_pc_d;  // PC of the outstanding request
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic in_run, in_wait, in_drop;
  logic rsp_live, rsp_stale;
  logic fire, push, pop;

  // The low target bits are architecturally zero for a word-aligned fetch.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^PCTargetE[1:0];

  assign in_run  = (state_q == S_RUN);
  assign in_wait = (state_q == S_WAIT);
  assign in_drop = (state_q == S_DROP);

  assign rsp_live  = in_wait && imem_rvalid;
  assign rsp_stale = in_drop && imem_rvalid;

  // Back-to-back request only when the arriving word and the new one both fit.
  // Gated by reset so the request is low for the whole reset interval.
  assign imem_req = !reset && !PCSrcE &&
                    ((in_run && (count_q < CNT_FULL)) ||
                     (rsp_live && (count_q < CNT_ALMOST)));
  assign imem_addr = pc_q;

  assign fire = imem_req && imem_gnt;
  assign push = rsp_live && !PCSrcE;
  assign pop  = ValidD && !StallD && !PCSrcE;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (PCSrcE) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      pc_d     = {PCTargetE[31:2], 2'b00};
      // A response landing this very cycle is consumed (and dropped) here;
      // otherwise the one still in flight must be swallowed later.
      if ((in_wait || in_drop) && !imem_rvalid) begin
        state_d = S_DROP;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      if (rsp_live || rsp_stale) begin
        state_d = S_RUN;
      end
      if (fire) begin
        pc_d     = pc_q + 32'd4;
        req_pc_d = pc_q;
        state_d  = S_WAIT;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Buffer storage carries no reset; entries are qualified by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign ValidD   = (count_q != '0);
  assign InstrD   = instr_mem[rd_ptr_q];
  assign PCD      = pc_mem[rd_ptr_q];
  assign PCPlus4D = PCD + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-programmable
//   memory model; expected Decode entries go into a queue and a monitor
//   compares every entry Decode accepts against the queue head.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallD(StallD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
  );

  int checks;
  int failures;
  int lat;        // grant-to-rvalid distance in cycles
  int gnt_cnt;    // grants seen since last reset
  logic [31:0] sb [$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Called at the start of a cycle; holds reset for one cycle and returns at
  // the start of the first cycle after release.
  task automatic apply_reset(input logic st, input int l);
    reset  = 1'b1;
    PCSrcE = 1'b0;
    StallD = st;
    lat    = l;
    neg();
    chk("rst_validd", {31'd0, ValidD}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: one outstanding request, response lat cycles after the grant.
  initial begin : memory
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 1'b0;
    cnt = 0;
    paddr = '0;
    gnt_cnt = 0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
        imem_rvalid = 1'b0;
        gnt_cnt = 0;
      end else if (imem_req && imem_gnt) begin
        pend = 1'b1;
        cnt = lat;
        paddr = imem_addr;
        gnt_cnt++;
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = instr_of(paddr);
          pend = 1'b0;
        end
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    PCSrcE = 1'b0;
    PCTargetE = '0;
    StallD = 1'b0;
    imem_gnt = 1'b1;
    lat = 1;
    fork
      begin : monitor
        logic [31:0] e;
        forever begin
          neg();
          if (!reset && ValidD && !StallD && !PCSrcE) begin
            if (sb.size() == 0) begin
              chk("unexpected_pop_pcd", PCD, 32'hDEAD_BEEF);
            end else begin
              e = sb.pop_front();
              chk("sb_pcd", PCD, e);
              chk("sb_instr", InstrD, instr_of(e));
              chk("sb_pcplus4", PCPlus4D, e + 32'd4);
            end
          end
        end
      end
      begin : stimulus
        cyc();
        // 1: streaming with 1-cycle memory
        apply_reset(1'b0, 1);
        for (int i = 0; i < 8; i++) sb.push_back(32'(4 * i));
        neg();
        chk("t1_req0", {31'd0, imem_req}, 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        repeat (10) cyc();
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // 2: stall fills the buffer, release drains it in order
        apply_reset(1'b1, 1);
        repeat (6) cyc();
        neg();
        chk("t2_grants", 32'(gnt_cnt), 32'd4);
        chk("t2_req_full", {31'd0, imem_req}, 32'd0);
        chk("t2_valid", {31'd0, ValidD}, 32'd1);
        chk("t2_head_pc", PCD, 32'h0);
        for (int i = 0; i < 6; i++) sb.push_back(32'(4 * i));
        cyc();
        StallD = 1'b0;
        repeat (6) cyc();
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 3: redirect while waiting, stale word arrives two cycles later
        apply_reset(1'b0, 3);
        sb.push_back(32'h0000_0100);
        cyc();
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0103;
        neg();
        chk("t3_req_redirect", {31'd0, imem_req}, 32'd0);
        cyc();
        PCSrcE = 1'b0;
        neg();
        chk("t3_valid_after", {31'd0, ValidD}, 32'd0);
        chk("t3_req_drop", {31'd0, imem_req}, 32'd0);
        cyc();
        neg();
        chk("t3_req_stale", {31'd0, imem_req}, 32'd0);
        cyc();
        neg();
        chk("t3_req_target", {31'd0, imem_req}, 32'd1);
        chk("t3_addr_target", imem_addr, 32'h0000_0100);
        repeat (5) cyc();
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // 4: redirect coincident with rvalid
        apply_reset(1'b0, 1);
        sb.push_back(32'h0000_0200);
        sb.push_back(32'h0000_0204);
        cyc();
        PCSrcE = 1'b1;
        PCTargetE = 32'h0000_0200;
        neg();
        chk("t4_req_redirect", {31'd0, imem_req}, 32'd0);
        cyc();
        PCSrcE = 1'b0;
        neg();
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        chk("t4_addr", imem_addr, 32'h0000_0200);
        chk("t4_valid", {31'd0, ValidD}, 32'd0);
        repeat (4) cyc();
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // 5: fetch PC wraps at 2^32
        apply_reset(1'b0, 1);
        sb.push_back(32'hFFFF_FFFC);
        sb.push_back(32'h0000_0000);
        cyc();
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        cyc();
        PCSrcE = 1'b0;
        neg();
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        cyc();
        neg();
        chk("t5_addr_wrap", imem_addr, 32'h0);
        cyc();
        neg();
        chk("t5_pcd_top", PCD, 32'hFFFF_FFFC);
        chk("t5_pcplus4_wrap", PCPlus4D, 32'h0);
        repeat (2) cyc();
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);

        // 6: reset with three entries buffered and a request outstanding
        apply_reset(1'b1, 1);
        repeat (3) cyc();
        neg();
        chk("t6_valid_pre", {31'd0, ValidD}, 32'd1);
        cyc();
        apply_reset(1'b0, 1);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        neg();
        chk("t6_req_after", {31'd0, imem_req}, 32'd1);
        chk("t6_addr_after", imem_addr, 32'h0);
        repeat (4) cyc();
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        reset = 1'b1;
        cyc();
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
